// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Width that holds the largest of the three timing parameters without wrapping.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_lock.sv
// Consecutive-high filter: stable_o once raw_i has been sampled high LockFilter times in a row.
module lock_filter #(
  parameter int LockFilter = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic stable_o
);

  localparam int W = $clog2(LockFilter + 1);
  localparam logic [W-1:0] CntMax = W'(LockFilter);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || !raw_i)
      r_cnt <= '0;
    else if (r_cnt != CntMax)
      r_cnt <= r_cnt + 1'b1;
  end

  assign stable_o = (r_cnt == CntMax);

endmodule

// File: rtl/reset_sequencer.sv
// Orders per-subsystem reset releases after a filtered PLL lock and a minimum hold time.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NumOutputs = 3,
  parameter int LockFilter = 8,
  parameter int HoldCycles = 1024,
  parameter int StageGap   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  pll_locked_i,
  input  logic                  sw_rst_i,
  output logic [NumOutputs-1:0] rst_o,
  output logic                  ready_o,
  output logic                  fault_o
);

  localparam int CW = cnt_w(LockFilter, HoldCycles, StageGap);
  localparam int IW = $clog2(NumOutputs + 1);
  localparam logic [CW-1:0] HoldLast = CW'(HoldCycles - 1);
  localparam logic [CW-1:0] GapLast  = CW'(StageGap - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(NumOutputs - 1);

  generate
    if (NumOutputs < 1 || NumOutputs > 16) begin : g_bad_num_outputs
      $error("reset_sequencer: NumOutputs must be in 1..16");
    end
    if (LockFilter < 1) begin : g_bad_lock_filter
      $error("reset_sequencer: LockFilter must be >= 1");
    end
    if (HoldCycles < 1) begin : g_bad_hold_cycles
      $error("reset_sequencer: HoldCycles must be >= 1");
    end
    if (StageGap < 1) begin : g_bad_stage_gap
      $error("reset_sequencer: StageGap must be >= 1");
    end
  endgenerate

  seq_state_e            r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt, w_cnt_inc;
  logic [IW-1:0]         r_idx, w_idx;
  logic [NumOutputs-1:0] r_rst, w_rst;
  logic                  r_ready, w_ready;
  logic                  r_fault, w_fault;
  logic                  w_stable;

  lock_filter #(.LockFilter(LockFilter)) u_lock_filter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .raw_i    (pll_locked_i),
    .stable_o (w_stable)
  );

  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_rst   = r_rst;
    w_ready = r_ready;
    w_fault = r_fault;

    // Releases go in index order, so shifting a zero in from bit 0 frees the next stage.
    case (r_state)
      WAIT_LOCK: begin
        if (w_stable && pll_locked_i) begin
          w_state = HOLD;
          w_cnt   = '0;
        end
      end
      HOLD: begin
        if (r_cnt == HoldLast) begin
          w_cnt = '0;
          w_rst = r_rst << 1;
          w_idx = IW'(1);
          if (NumOutputs == 1) begin
            w_state = RUN;
            w_ready = 1'b1;
          end else begin
            w_state = RELEASE;
          end
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      RELEASE: begin
        if (r_cnt == GapLast) begin
          w_cnt = '0;
          w_rst = r_rst << 1;
          w_idx = r_idx + 1'b1;
          if (r_idx == IdxLast) begin
            w_state = RUN;
            w_ready = 1'b1;
          end
        end else begin
          w_cnt = w_cnt_inc;
        end
      end
      default: ;
    endcase

    // Lock loss outranks a soft reset; neither applies while still filtering lock.
    if (r_state != WAIT_LOCK) begin
      if (!pll_locked_i) begin
        w_state = WAIT_LOCK;
        w_cnt   = '0;
        w_idx   = '0;
        w_rst   = '1;
        w_ready = 1'b0;
        if (r_state == RUN) w_fault = 1'b1;
      end else if (sw_rst_i) begin
        w_state = HOLD;
        w_cnt   = '0;
        w_idx   = '0;
        w_rst   = '1;
        w_ready = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= WAIT_LOCK;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst   <= '1;
      r_ready <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_rst   <= w_rst;
      r_ready <= w_ready;
      r_fault <= w_fault;
    end
  end

  assign rst_o   = r_rst;
  assign ready_o = r_ready;
  assign fault_o = r_fault;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: release timing, lock filtering, lock loss, soft reset and a 1-output variant.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, lock, sw;
  logic [2:0] rso;
  logic       rdy, flt;

  logic       rst1, lock1, sw1;
  logic [0:0] rso1;
  logic       rdy1, flt1;

  int e;
  int n_chk;
  int n_bad;

  reset_sequencer #(
    .NumOutputs(3), .LockFilter(8), .HoldCycles(1024), .StageGap(16)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .pll_locked_i(lock), .sw_rst_i(sw),
    .rst_o(rso), .ready_o(rdy), .fault_o(flt)
  );

  reset_sequencer #(
    .NumOutputs(1), .LockFilter(1), .HoldCycles(1), .StageGap(16)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .pll_locked_i(lock1), .sw_rst_i(sw1),
    .rst_o(rso1), .ready_o(rdy1), .fault_o(flt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) tick();
  endtask

  // Reset sampled on the next edge; edge 0 is the first edge after rst drops.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk("rst_rso", 32'(rso), 32'h7);
    chk("rst_rdy", 32'(rdy), 32'h0);
    chk("rst_flt", 32'(flt), 32'h0);
    tick();
    tick();
    rst = 1'b0;
    e = -1;
  endtask

  initial begin
    n_chk = 0; n_bad = 0; e = 0;
    rst = 1'b1; lock = 1'b1; sw = 1'b0;
    rst1 = 1'b1; lock1 = 1'b1; sw1 = 1'b0;

    // Single-output variant: HOLD at edge 1, release and ready at edge 2.
    tick(); tick();
    chk("n1_rst_rso", 32'(rso1), 32'h1);
    chk("n1_rst_rdy", 32'(rdy1), 32'h0);
    rst1 = 1'b0; e = -1;
    tick(); chk("n1_e0_rso", 32'(rso1), 32'h1);
    tick(); chk("n1_e1_rso", 32'(rso1), 32'h1);
    chk("n1_e1_rdy", 32'(rdy1), 32'h0);
    tick(); chk("n1_e2_rso", 32'(rso1), 32'h0);
    chk("n1_e2_rdy", 32'(rdy1), 32'h1);
    lock1 = 1'b0;
    tick(); chk("n1_loss_rso", 32'(rso1), 32'h1);
    chk("n1_loss_rdy", 32'(rdy1), 32'h0);
    chk("n1_loss_flt", 32'(flt1), 32'h1);
    lock1 = 1'b1;
    run_to(5); chk("n1_e5_rso", 32'(rso1), 32'h1);
    run_to(6); chk("n1_e6_rso", 32'(rso1), 32'h0);
    chk("n1_e6_rdy", 32'(rdy1), 32'h1);
    chk("n1_e6_flt", 32'(flt1), 32'h1);
    rst1 = 1'b1;
    tick(); chk("n1_rrst_rso", 32'(rso1), 32'h1);
    chk("n1_rrst_rdy", 32'(rdy1), 32'h0);
    chk("n1_rrst_flt", 32'(flt1), 32'h0);

    // Nominal sequence with lock high throughout.
    do_reset();
    run_to(1031); chk("nom_1031", 32'(rso), 32'h7);
    run_to(1032); chk("nom_1032", 32'(rso), 32'h6);
    run_to(1047); chk("nom_1047", 32'(rso), 32'h6);
    run_to(1048); chk("nom_1048", 32'(rso), 32'h4);
    run_to(1063); chk("nom_1063", 32'(rso), 32'h4);
    chk("nom_1063_rdy", 32'(rdy), 32'h0);
    run_to(1064); chk("nom_1064", 32'(rso), 32'h0);
    chk("nom_1064_rdy", 32'(rdy), 32'h1);
    chk("nom_1064_flt", 32'(flt), 32'h0);

    // Lock loss in RUN: fault, then re-filter from edge 1101 (HOLD at 1109).
    run_to(1099);
    lock = 1'b0;
    tick();
    chk("loss_rso", 32'(rso), 32'h7);
    chk("loss_rdy", 32'(rdy), 32'h0);
    chk("loss_flt", 32'(flt), 32'h1);
    lock = 1'b1;
    run_to(2132); chk("loss_2132", 32'(rso), 32'h7);
    run_to(2133); chk("loss_2133", 32'(rso), 32'h6);
    run_to(2165); chk("loss_2165", 32'(rso), 32'h0);
    chk("loss_2165_rdy", 32'(rdy), 32'h1);
    chk("loss_2165_flt", 32'(flt), 32'h1);

    // Soft reset sampled at edge 1040: re-hold without re-filtering.
    do_reset();
    run_to(1039); chk("sw_1039", 32'(rso), 32'h6);
    sw = 1'b1;
    tick();
    sw = 1'b0;
    run_to(1041); chk("sw_1041", 32'(rso), 32'h7);
    chk("sw_1041_rdy", 32'(rdy), 32'h0);
    run_to(2063); chk("sw_2063", 32'(rso), 32'h7);
    run_to(2064); chk("sw_2064", 32'(rso), 32'h6);
    run_to(2096); chk("sw_2096", 32'(rso), 32'h0);
    chk("sw_2096_rdy", 32'(rdy), 32'h1);
    chk("sw_2096_flt", 32'(flt), 32'h0);

    // Lock glitch low at edge 7: HOLD only at edge 16, bit 0 at 1040.
    do_reset();
    run_to(6);
    lock = 1'b0;
    tick();
    lock = 1'b1;
    run_to(1032); chk("glitch_1032", 32'(rso), 32'h7);
    run_to(1039); chk("glitch_1039", 32'(rso), 32'h7);
    run_to(1040); chk("glitch_1040", 32'(rso), 32'h6);
    run_to(1056); chk("glitch_1056", 32'(rso), 32'h4);
    // rst_i sampled at edge 1060, mid-RELEASE.
    run_to(1059);
    do_reset();

    // Soft reset and lock loss together in RUN: lock loss wins.
    run_to(1069);
    lock = 1'b0;
    sw = 1'b1;
    tick();
    lock = 1'b1;
    sw = 1'b0;
    chk("both_rso", 32'(rso), 32'h7);
    chk("both_flt", 32'(flt), 32'h1);
    run_to(2094); chk("both_2094", 32'(rso), 32'h7);
    run_to(2103); chk("both_2103", 32'(rso), 32'h6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
